// File: rtl/mv_pkg.sv
// rtl/mv_pkg.sv - shared types and helpers for the matrix-vector engine
//
// Holds the controller state enum, the accumulator width function and the
// narrow() helper used by every MAC lane. Saturating vs. wrapping narrowing is
// chosen by the caller; mv_mac_lane selects it with macro MV_SATURATE_EN.
package mv_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // narrow() works on fixed-size containers so one function serves every
  // parameterisation: element widths up to 64 bits, dimensions up to 64.
  localparam int NARROW_OUT_W = 64;
  localparam int NARROW_IN_W  = 2 * NARROW_OUT_W + 6;

  // Sum of DIMENSION products of two WIDTH-bit signed values cannot overflow.
  function automatic int acc_w(input int width, input int dim);
    return 2 * width + $clog2(dim);
  endfunction

  // Returns val clamped to the signed range of 'width' bits when sat is set,
  // otherwise val untouched; the caller keeps the low 'width' bits, which
  // yields two's-complement wrap in the non-saturating case.
  function automatic logic signed [NARROW_IN_W-1:0] narrow(
    input logic signed [NARROW_IN_W-1:0] val,
    input int                            width,
    input logic                          sat
  );
    logic signed [NARROW_IN_W-1:0] one;
    logic signed [NARROW_IN_W-1:0] hi;
    logic signed [NARROW_IN_W-1:0] lo;
    one = NARROW_IN_W'(1);
    hi  = (one << (width - 1)) - one;
    lo  = ~hi;
    if (sat && (val > hi)) begin
      return hi;
    end else if (sat && (val < lo)) begin
      return lo;
    end
    return val;
  endfunction

endpackage

// File: rtl/mv_mac_lane.sv
// rtl/mv_mac_lane.sv - one matrix row: multiplier, accumulator and output narrowing
//
// Ports:
//   clk, rst   clock, synchronous active-low reset (clears acc and out)
//   clear      zero the accumulator (job accept)
//   en         accumulate m*v this edge
//   last       this is the final term: register the narrowed result into out
//   m, v       signed WIDTH-bit operands for the current k
//   out        registered, narrowed row result (held until the next last term)
// Macro MV_SATURATE_EN selects clamping instead of wrapping on narrowing.
module mv_mac_lane
  import mv_pkg::*;
#(
  parameter int DIMENSION = 16,
  parameter int WIDTH     = 8,
  parameter int SHIFT     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic             last,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] v,
  output logic [WIDTH-1:0] out
);

  localparam int ACC_W = acc_w(WIDTH, DIMENSION);

`ifdef MV_SATURATE_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  logic signed [ACC_W-1:0]   acc;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   sum;
  logic signed [ACC_W-1:0]   shifted;

  // Operands are sign-extended to the product width before multiplying.
  assign prod    = (2*WIDTH)'($signed(m)) * (2*WIDTH)'($signed(v));
  assign sum     = acc + ACC_W'(prod);
  assign shifted = sum >>> SHIFT;

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc <= '0;
      out <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
      if (last) begin
        out <= WIDTH'(narrow(NARROW_IN_W'(shifted), WIDTH, SAT));
      end
    end
  end

endmodule

// File: rtl/mv_systolic.sv
// rtl/mv_systolic.sv - signed matrix-vector multiplier, one column per cycle
//
// Computes out[r] = narrow(sum_k M(r,k)*V(k) >>> SHIFT) over DIMENSION cycles.
// Ports:
//   clk, rst             clock, synchronous active-low reset
//   in_valid/in_ready    operand handshake (M row-major, V), accepted in IDLE
//   abort                cancel the job in COMPUTE or DONE
//   out_valid/out_ready  result handshake; out_data held while waiting
//   busy                 controller not in IDLE
// Macro MV_SATURATE_EN (via mv_mac_lane) clamps instead of wrapping results.
module mv_systolic
  import mv_pkg::*;
#(
  parameter int DIMENSION = 16,
  parameter int WIDTH     = 8,
  parameter int SHIFT     = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DIMENSION*DIMENSION*WIDTH-1:0] M,
  input  logic [DIMENSION*WIDTH-1:0]       V,
  input  logic                             abort,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DIMENSION*WIDTH-1:0]       out_data,
  output logic                             busy
);

  localparam int K_W = (DIMENSION > 1) ? $clog2(DIMENSION) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(DIMENSION - 1);

  state_t                             state;
  logic [K_W-1:0]                     k;
  logic [DIMENSION*DIMENSION*WIDTH-1:0] m_reg;
  logic [DIMENSION*WIDTH-1:0]         v_reg;
  int                                 k_idx;

  logic lane_clear;
  logic lane_en;
  logic lane_last;

  assign k_idx      = int'(k);
  assign lane_clear = (state == IDLE) && in_valid;
  // An abort cancels the accumulate of that edge so out_data stays untouched.
  assign lane_en    = (state == COMPUTE) && !abort;
  assign lane_last  = (k == K_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      k         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            m_reg    <= M;
            v_reg    <= V;
            k        <= '0;
            state    <= COMPUTE;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        COMPUTE: begin
          if (abort) begin
            state    <= IDLE;
            k        <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else if (k == K_LAST) begin
            state     <= DONE;
            k         <= '0;
            out_valid <= 1'b1;
          end else begin
            k <= k + K_W'(1);
          end
        end
        DONE: begin
          // Returning to IDLE here means the next accept is one edge later.
          if (abort || out_ready) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          k         <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  for (genvar r = 0; r < DIMENSION; r++) begin : g_lane
    mv_mac_lane #(
      .DIMENSION(DIMENSION),
      .WIDTH    (WIDTH),
      .SHIFT    (SHIFT)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .clear(lane_clear),
      .en   (lane_en),
      .last (lane_last),
      .m    (m_reg[(r*DIMENSION + k_idx)*WIDTH +: WIDTH]),
      .v    (v_reg[k_idx*WIDTH +: WIDTH]),
      .out  (out_data[r*WIDTH +: WIDTH])
    );
  end

endmodule

// File: doc/mv_systolic.md
MV_SYSTOLIC -- requirements
Module: mv_systolic

Interface
REQ-001 SHALL provide parameter DIMENSION, default 16: matrix rows, matrix columns and vector length; legal range 1..64.
REQ-002 SHALL provide parameter WIDTH, default 8: bits per signed element of M, V and out_data.
REQ-003 SHALL provide parameter SHIFT, default 0: arithmetic right shift applied to each accumulator before output narrowing; legal range 0..2*WIDTH.
REQ-004 SHALL have port clk, input, 1 bit: the only clock; all logic is sampled on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: M and V are valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block can accept an operand set.
REQ-008 SHALL have port M, input, DIMENSION*DIMENSION*WIDTH bits: signed matrix, row-major; element (r,k) sits at bits [(r*DIMENSION+k)*WIDTH +: WIDTH].
REQ-009 SHALL have port V, input, DIMENSION*WIDTH bits: signed vector; element k sits at bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port abort, input, 1 bit: synchronous cancel of the current job.
REQ-011 SHALL have port out_valid, output, 1 bit: out_data holds a result.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 SHALL have port out_data, output, DIMENSION*WIDTH bits: signed result; element r sits at bits [r*WIDTH +: WIDTH].
REQ-014 SHALL have port busy, output, 1 bit: the FSM is not in IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, COMPUTE and DONE; in_ready=1 only in IDLE, and busy=1 in COMPUTE and DONE.
REQ-016 SHALL accept a job on an edge where in_valid&&in_ready; M and V are registered on that edge, all accumulators clear, k=0, and the FSM moves to COMPUTE.
REQ-017 In COMPUTE, SHALL add M(r,k)*V(k) into acc[r] for every r in parallel on each edge, then increment k.
REQ-018 Products SHALL be signed 2*WIDTH-bit values; accumulators SHALL be ACC_W=2*WIDTH+clog2(DIMENSION) bits wide, so no accumulator overflow is possible.
REQ-019 On the edge where k=DIMENSION-1, SHALL register out_data[r]=narrow((acc[r]+last product)>>>SHIFT) and move to DONE; out_valid therefore rises exactly DIMENSION cycles after the accepting edge.
REQ-020 In DONE, out_valid SHALL be 1 and out_data SHALL be held stable until an edge with out_ready=1, which moves the FSM to IDLE; out_valid falls on that edge.
REQ-021 A new job SHALL NOT be accepted on the same edge as the result handshake; the earliest next accept is the following edge.
REQ-022 abort=1 in COMPUTE or DONE SHALL force IDLE on the next edge: out_valid=0 and out_data unchanged; abort in IDLE has no effect.
REQ-023 abort SHALL take priority over a simultaneous out_ready handshake; in_valid SHALL be ignored while the FSM is not in IDLE.
REQ-024 For DIMENSION=1, COMPUTE SHALL last exactly one cycle.

Reset
REQ-025 When rst=0 at an edge, SHALL set state=IDLE, k=0, every acc=0, out_data=0, out_valid=0 and busy=0; in_ready SHALL be 1 from the first edge after release.
REQ-026 Reset SHALL override abort and both handshakes, including mid-COMPUTE.

Configuration
REQ-027 With macro MV_SATURATE_EN defined, narrow() SHALL clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-028 Without MV_SATURATE_EN, narrow() SHALL keep the low WIDTH bits (two's-complement wrap).

Structure
REQ-029 Package mv_pkg SHALL hold the state enum, the ACC_W function and the narrow/saturate function.
REQ-030 SHALL use one sub-module, mv_mac_lane: one row's multiplier, accumulator and narrowing; mv_systolic instantiates DIMENSION lanes plus the FSM and counter.

Verification (DIMENSION=4, WIDTH=8, SHIFT=0)
REQ-031 M=identity, V=[1,2,3,4] -> out_data=[1,2,3,4]; out_valid high 4 cycles after the accept edge.
REQ-032 All M=127, all V=127 (acc=64516) -> every element is 127 with MV_SATURATE_EN and 4 without.
REQ-033 All M=-128, all V=127 (acc=-65024) -> every element is -128 with MV_SATURATE_EN and 0 without.
REQ-034 out_ready held low for 3 cycles in DONE -> out_data stable, in_ready=0; out_ready=1 -> IDLE on the next edge, and a new accept is possible one edge later.
REQ-035 rst=0 at k=2 -> IDLE on that edge, all outputs 0; a following identity job produces the correct result.
REQ-036 abort at k=1 -> IDLE, out_valid never asserts, out_data retains its previous value.
